// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage and its performance counters.
package wb_pkg;

    // Default width of every performance counter.
    localparam int CNT_W_DEF = 32;

    // Register-file writeback source select (2'b11 selects zero).
    typedef enum logic [1:0] {
        WB_PC4 = 2'b00,
        WB_ALU = 2'b01,
        WB_LD  = 2'b10
    } wbsel_e;

    // Performance counter read select.
    typedef enum logic [1:0] {
        CNT_CYC = 2'b00,
        CNT_RET = 2'b01,
        CNT_BR  = 2'b10,
        CNT_MP  = 2'b11
    } cnt_sel_e;

    // Writeback data mux; the unused encoding returns zero.
    function automatic logic [31:0] wb_mux(
        input logic [1:0]  sel,
        input logic [31:0] pc4,
        input logic [31:0] alu,
        input logic [31:0] ld
    );
        logic [31:0] res;
        res = 32'h0;
        case (sel)
            WB_PC4:  res = pc4;
            WB_ALU:  res = alu;
            WB_LD:   res = ld;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_stage_perf_if.sv
// MEM/WB pipeline-register bundle plus the register-file write port it produces.
interface wb_stage_perf_if;
    logic [31:0] pc_four_WB;
    logic [31:0] alu_WB;
    logic [31:0] i_ld_data_WB;
    logic [4:0]  WB_Rd_addr;
    logic        i_rdwren_WB;
    logic        i_insnvld_WB;
    logic [1:0]  i_wbsel_WB;
    logic        i_ctrl_WB;
    logic        i_mispred_WB;
    logic [31:0] i_pc_debug_WB;
    logic [31:0] o_rd_wdata;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;

    // Pipeline side: drives the MEM/WB fields, observes the register-file write.
    modport master (
        output pc_four_WB, alu_WB, i_ld_data_WB, WB_Rd_addr, i_rdwren_WB,
               i_insnvld_WB, i_wbsel_WB, i_ctrl_WB, i_mispred_WB, i_pc_debug_WB,
        input  o_rd_wdata, o_rd_wren, o_rd_addr
    );

    // Writeback stage side.
    modport slave (
        input  pc_four_WB, alu_WB, i_ld_data_WB, WB_Rd_addr, i_rdwren_WB,
               i_insnvld_WB, i_wbsel_WB, i_ctrl_WB, i_mispred_WB, i_pc_debug_WB,
        output o_rd_wdata, o_rd_wren, o_rd_addr
    );
endinterface

// File: rtl/perf_sat_cnt.sv
// Saturating up-counter with synchronous clear and freeze (clear beats freeze beats increment).
module perf_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_freeze,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Count up, sticking at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_freeze) begin
            r_cnt <= r_cnt;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/wb_stage_perf.sv
// Writeback stage: register-file write mux, retire view and performance counters.
// Optional mispredict-streak alarm is built when WB_MISPRED_STREAK_EN is defined.
module wb_stage_perf
    import wb_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STREAK_TH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    wb_stage_perf_if.slave    wb,
    input  logic              i_cnt_clr,
    input  logic              i_cnt_freeze,
    input  logic [1:0]        i_cnt_sel,
    output logic              o_insn_vld,
    output logic [31:0]       o_pc_debug,
    output logic [CNT_W-1:0]  o_cnt_rdata,
    output logic              o_mispred_alarm
);
    logic [3:0]       w_inc;
    logic [CNT_W-1:0] w_cnt [4];
    logic             w_br_vld;
    logic             r_insn_vld;
    logic [31:0]      r_pc_debug;
    logic [CNT_W-1:0] r_cnt_rdata;

    // Zero-latency writeback path; x0 writes are suppressed.
    assign wb.o_rd_wdata = wb_mux(wb.i_wbsel_WB, wb.pc_four_WB, wb.alu_WB, wb.i_ld_data_WB);
    assign wb.o_rd_wren  = wb.i_rdwren_WB & wb.i_insnvld_WB & (wb.WB_Rd_addr != 5'd0);
    assign wb.o_rd_addr  = wb.WB_Rd_addr;

    // Increment strobes, indexed by cnt_sel_e encoding.
    assign w_br_vld          = wb.i_insnvld_WB & wb.i_ctrl_WB;
    assign w_inc[CNT_CYC]    = 1'b1;
    assign w_inc[CNT_RET]    = wb.i_insnvld_WB;
    assign w_inc[CNT_BR]     = w_br_vld;
    assign w_inc[CNT_MP]     = w_br_vld & wb.i_mispred_WB;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            perf_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_clr    (i_cnt_clr),
                .i_freeze (i_cnt_freeze),
                .i_inc    (w_inc[gi]),
                .o_cnt    (w_cnt[gi])
            );
        end
    endgenerate

    // Retire view and registered counter read port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_insn_vld  <= 1'b0;
            r_pc_debug  <= 32'h0;
            r_cnt_rdata <= '0;
        end else begin
            r_insn_vld  <= wb.i_insnvld_WB;
            r_pc_debug  <= wb.i_pc_debug_WB;
            r_cnt_rdata <= w_cnt[i_cnt_sel];
        end
    end

    assign o_insn_vld  = r_insn_vld;
    assign o_pc_debug  = r_pc_debug;
    assign o_cnt_rdata = r_cnt_rdata;

`ifdef WB_MISPRED_STREAK_EN
    localparam logic [3:0] TH4 = 4'(STREAK_TH);
    logic [3:0] r_streak;
    logic [3:0] w_streak_next;
    logic       r_alarm;

    // Mispredicted branches extend the streak (capped), correct branches reset it.
    always_comb begin
        w_streak_next = r_streak;
        if (w_br_vld) begin
            if (wb.i_mispred_WB) begin
                if (r_streak != TH4) w_streak_next = r_streak + 4'd1;
            end else begin
                w_streak_next = 4'd0;
            end
        end
    end

    // Alarm tracks the streak value being written, so it rises with the threshold edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_cnt_clr) begin
            r_streak <= 4'd0;
            r_alarm  <= 1'b0;
        end else begin
            r_streak <= w_streak_next;
            r_alarm  <= (w_streak_next == TH4);
        end
    end

    assign o_mispred_alarm = r_alarm;
`else
    logic w_unused_th;
    assign w_unused_th     = (STREAK_TH == 0);
    assign o_mispred_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stage_perf.sv
// Directed, table-driven bench for wb_stage_perf (32-bit and 4-bit counter builds).
module tb_wb_stage_perf;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        cnt_freeze = 1'b0;
    logic [1:0]  cnt_sel = 2'b00;
    logic        insn_vld;
    logic [31:0] pc_debug;
    logic [31:0] cnt_rdata;
    logic        alarm;
    logic        insn_vld4;
    logic [31:0] pc_debug4;
    logic [3:0]  cnt_rdata4;
    logic        alarm4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_perf_if u_if ();
    wb_stage_perf_if u_if4 ();

    wb_stage_perf #(.CNT_W(32), .STREAK_TH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .wb(u_if.slave),
        .i_cnt_clr(cnt_clr), .i_cnt_freeze(cnt_freeze), .i_cnt_sel(cnt_sel),
        .o_insn_vld(insn_vld), .o_pc_debug(pc_debug),
        .o_cnt_rdata(cnt_rdata), .o_mispred_alarm(alarm)
    );

    // Idle 4-bit instance used only to watch cyc_cnt saturate.
    assign u_if4.pc_four_WB    = 32'h0;
    assign u_if4.alu_WB        = 32'h0;
    assign u_if4.i_ld_data_WB  = 32'h0;
    assign u_if4.WB_Rd_addr    = 5'd0;
    assign u_if4.i_rdwren_WB   = 1'b0;
    assign u_if4.i_insnvld_WB  = 1'b0;
    assign u_if4.i_wbsel_WB    = 2'b00;
    assign u_if4.i_ctrl_WB     = 1'b0;
    assign u_if4.i_mispred_WB  = 1'b0;
    assign u_if4.i_pc_debug_WB = 32'h0;

    wb_stage_perf #(.CNT_W(4), .STREAK_TH(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .wb(u_if4.slave),
        .i_cnt_clr(1'b0), .i_cnt_freeze(1'b0), .i_cnt_sel(2'b00),
        .o_insn_vld(insn_vld4), .o_pc_debug(pc_debug4),
        .o_cnt_rdata(cnt_rdata4), .o_mispred_alarm(alarm4)
    );

    typedef struct {
        logic [1:0]  wbsel;
        logic [4:0]  rd;
        logic        rdwren;
        logic        vld;
        logic [31:0] exp_wdata;
        logic        exp_wren;
    } wb_vec_t;

    typedef struct {
        logic vld;
        logic ctrl;
        logic mispred;
    } insn_vec_t;

    typedef struct {
        logic mispred;
        logic exp_alarm;
    } streak_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic vld, input logic ctrl, input logic mp);
        u_if.i_insnvld_WB = vld;
        u_if.i_ctrl_WB    = ctrl;
        u_if.i_mispred_WB = mp;
    endtask

    wb_vec_t     wb_tab [7];
    insn_vec_t   insn_tab [11];
    streak_vec_t streak_tab [9];
    logic [31:0] exp_cnts [3];

    initial begin
        // Writeback mux / write-enable vectors (pc4=1004, alu=A5A50001, ld=DEADBEEF).
        wb_tab[0] = '{2'b10, 5'd5,  1'b1, 1'b1, 32'hDEADBEEF, 1'b1};
        wb_tab[1] = '{2'b10, 5'd0,  1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
        wb_tab[2] = '{2'b00, 5'd7,  1'b1, 1'b1, 32'h00001004, 1'b1};
        wb_tab[3] = '{2'b01, 5'd31, 1'b1, 1'b1, 32'hA5A50001, 1'b1};
        wb_tab[4] = '{2'b11, 5'd3,  1'b1, 1'b1, 32'h00000000, 1'b1};
        wb_tab[5] = '{2'b01, 5'd3,  1'b0, 1'b1, 32'hA5A50001, 1'b0};
        wb_tab[6] = '{2'b01, 5'd3,  1'b1, 1'b0, 32'hA5A50001, 1'b0};

        // 10 valid instructions: 4 branches (2 mispredicted), one stray mispred on a
        // non-branch, then a bubble carrying branch+mispred that must not count.
        insn_tab[0]  = '{1'b1, 1'b0, 1'b0};
        insn_tab[1]  = '{1'b1, 1'b1, 1'b0};
        insn_tab[2]  = '{1'b1, 1'b0, 1'b0};
        insn_tab[3]  = '{1'b1, 1'b1, 1'b1};
        insn_tab[4]  = '{1'b1, 1'b0, 1'b0};
        insn_tab[5]  = '{1'b1, 1'b1, 1'b0};
        insn_tab[6]  = '{1'b1, 1'b0, 1'b0};
        insn_tab[7]  = '{1'b1, 1'b1, 1'b1};
        insn_tab[8]  = '{1'b1, 1'b0, 1'b1};
        insn_tab[9]  = '{1'b1, 1'b0, 1'b0};
        insn_tab[10] = '{1'b0, 1'b1, 1'b1};
        exp_cnts[0] = 32'd10;
        exp_cnts[1] = 32'd4;
        exp_cnts[2] = 32'd2;

        // Branch outcomes M M M C M M M M C, alarm sampled after each edge.
        streak_tab[0] = '{1'b1, 1'b0};
        streak_tab[1] = '{1'b1, 1'b0};
        streak_tab[2] = '{1'b1, 1'b0};
        streak_tab[3] = '{1'b0, 1'b0};
        streak_tab[4] = '{1'b1, 1'b0};
        streak_tab[5] = '{1'b1, 1'b0};
        streak_tab[6] = '{1'b1, 1'b0};
`ifdef WB_MISPRED_STREAK_EN
        streak_tab[7] = '{1'b1, 1'b1};
`else
        streak_tab[7] = '{1'b1, 1'b0};
`endif
        streak_tab[8] = '{1'b0, 1'b0};

        u_if.pc_four_WB    = 32'h00001004;
        u_if.alu_WB        = 32'hA5A50001;
        u_if.i_ld_data_WB  = 32'hDEADBEEF;
        u_if.i_pc_debug_WB = 32'h0;
        u_if.WB_Rd_addr    = 5'd0;
        u_if.i_rdwren_WB   = 1'b0;
        u_if.i_wbsel_WB    = 2'b00;
        set_insn(1'b0, 1'b0, 1'b0);

        // Writeback path while reset is held: must be independent of reset.
        for (int i = 0; i < 7; i++) begin
            u_if.i_wbsel_WB   = wb_tab[i].wbsel;
            u_if.WB_Rd_addr   = wb_tab[i].rd;
            u_if.i_rdwren_WB  = wb_tab[i].rdwren;
            u_if.i_insnvld_WB = wb_tab[i].vld;
            #2;
            check($sformatf("wdata[%0d]", i), 64'(u_if.o_rd_wdata), 64'(wb_tab[i].exp_wdata));
            check($sformatf("wren[%0d]", i), 64'(u_if.o_rd_wren), 64'(wb_tab[i].exp_wren));
            check($sformatf("raddr[%0d]", i), 64'(u_if.o_rd_addr), 64'(wb_tab[i].rd));
        end
        set_insn(1'b0, 1'b0, 1'b0);
        u_if.i_rdwren_WB = 1'b0;

        // Reset for 3 edges, then release with no activity.
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_rdata", 64'(cnt_rdata), 64'd0);
        check("rst_insn_vld", 64'(insn_vld), 64'd0);
        check("rst_pc_debug", 64'(pc_debug), 64'd0);
        check("rst_alarm", 64'(alarm), 64'd0);
        step();
        check("cyc_1", 64'(cnt_rdata), 64'd1);
        step();
        check("cyc_2", 64'(cnt_rdata), 64'd2);
        check("cyc4_2", 64'(cnt_rdata4), 64'd2);

        // Retire view has one cycle of latency.
        set_insn(1'b1, 1'b0, 1'b0);
        u_if.i_pc_debug_WB = 32'h00000100;
        step();
        check("ret_vld_hi", 64'(insn_vld), 64'd1);
        check("ret_pc_100", 64'(pc_debug), 64'h100);
        set_insn(1'b0, 1'b0, 1'b0);
        u_if.i_pc_debug_WB = 32'h00000200;
        step();
        check("ret_vld_lo", 64'(insn_vld), 64'd0);
        check("ret_pc_200", 64'(pc_debug), 64'h200);

        // Start the instruction mix from cleared counters.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 11; i++) begin
            set_insn(insn_tab[i].vld, insn_tab[i].ctrl, insn_tab[i].mispred);
            step();
        end
        set_insn(1'b0, 1'b0, 1'b0);
        cnt_freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt_sel = 2'(i + 1);
            step();
            check($sformatf("mix_sel%0d", i + 1), 64'(cnt_rdata), 64'(exp_cnts[i]));
        end

        // Clear wins over a simultaneous valid mispredicted branch.
        cnt_freeze = 1'b0;
        cnt_clr = 1'b1;
        set_insn(1'b1, 1'b1, 1'b1);
        step();
        cnt_clr = 1'b0;
        set_insn(1'b0, 1'b0, 1'b0);
        cnt_freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            step();
            check($sformatf("clr_sel%0d", i), 64'(cnt_rdata), 64'd0);
        end

        // Free-run 3 cycles, then freeze cyc_cnt for 6 edges.
        cnt_sel = 2'b00;
        cnt_freeze = 1'b0;
        repeat (3) step();
        check("cyc_run", 64'(cnt_rdata), 64'd2);
        cnt_freeze = 1'b1;
        step();
        check("cyc_frz0", 64'(cnt_rdata), 64'd3);
        repeat (5) step();
        check("cyc_frz5", 64'(cnt_rdata), 64'd3);
        cnt_freeze = 1'b0;

        // Mispredict streak / alarm.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("alarm_clr", 64'(alarm), 64'd0);
        for (int i = 0; i < 9; i++) begin
            set_insn(1'b1, 1'b1, streak_tab[i].mispred);
            step();
            check($sformatf("alarm[%0d]", i), 64'(alarm), 64'(streak_tab[i].exp_alarm));
        end
        set_insn(1'b0, 1'b0, 1'b0);

        // The 4-bit instance has seen well over 15 free-running edges.
        check("cyc4_sat", 64'(cnt_rdata4), 64'd15);
        repeat (3) step();
        check("cyc4_nowrap", 64'(cnt_rdata4), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
